// File: rtl/fir_filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_tap_sequencer
// Purpose  : Sample intake and per-tap address/control sequencing for a
//            time-multiplexed FIR datapath.
// Revision : 1.0 - initial release
// ============================================================================
module fir_filter_tap_sequencer #(
    parameter int TAP_COUNT  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid_in,
    input  logic [DATA_WIDTH-1:0] sample_data_in,
    output logic                  sample_ready_out,
    output logic                  write_en_out,
    output logic [ADDR_WIDTH-1:0] write_addr_out,
    output logic [DATA_WIDTH-1:0] write_data_out,
    output logic [ADDR_WIDTH-1:0] sample_addr_out,
    output logic [ADDR_WIDTH-1:0] coeff_addr_out,
    output logic                  tap_valid_out,
    output logic                  sample_zero_out,
    output logic                  overwrite_out,
    output logic                  last_tap_out,
    input  logic                  overflow_in,
    output logic                  overflow_sticky_out
);

    localparam int FILL_WIDTH = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(TAP_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [FILL_WIDTH-1:0] c_FILL_FULL = FILL_WIDTH'(TAP_COUNT);
    localparam logic [FILL_WIDTH-1:0] c_FILL_ONE  = FILL_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_tap_cnt;
    logic [FILL_WIDTH-1:0] r_fill_cnt;
    logic                  r_overflow_sticky;

    logic w_run;
    logic w_accept;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = sample_valid_in && !w_run;

    // Write port follows the handshake combinationally so the sample lands
    // in the buffer on the accept edge and is readable by tap 0.
    assign sample_ready_out = !w_run;
    assign write_en_out     = w_accept;
    assign write_addr_out   = w_accept ? r_wr_ptr : '0;
    assign write_data_out   = w_accept ? sample_data_in : '0;

    // Tap controls are decoded from registered state only.
    assign tap_valid_out   = w_run;
    assign sample_addr_out = w_run ? r_rd_ptr : '0;
    assign coeff_addr_out  = w_run ? r_tap_cnt : '0;
    assign overwrite_out   = w_run && (r_tap_cnt == '0);
    assign last_tap_out    = w_run && (r_tap_cnt == c_LAST_ADDR);
    assign sample_zero_out = w_run && ({1'b0, r_tap_cnt} >= r_fill_cnt);

    assign overflow_sticky_out = r_overflow_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_tap_cnt         <= '0;
            r_fill_cnt        <= '0;
            r_overflow_sticky <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid_in) begin
                        r_rd_ptr   <= r_wr_ptr;
                        r_wr_ptr   <= (r_wr_ptr == c_LAST_ADDR) ? '0 : r_wr_ptr + c_ADDR_ONE;
                        r_fill_cnt <= (r_fill_cnt == c_FILL_FULL) ? r_fill_cnt
                                                                  : r_fill_cnt + c_FILL_ONE;
                        r_tap_cnt  <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Walk backwards through the buffer: newest sample first.
                    r_rd_ptr <= (r_rd_ptr == '0) ? c_LAST_ADDR : r_rd_ptr - c_ADDR_ONE;
                    if (r_tap_cnt == c_LAST_ADDR) begin
                        r_tap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tap_cnt <= r_tap_cnt + c_ADDR_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A new output starts with a clean flag; otherwise overflow latches.
            if (w_accept) begin
                r_overflow_sticky <= 1'b0;
            end else if (overflow_in) begin
                r_overflow_sticky <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_filter_tap_sequencer
// Purpose  : Randomized check of two sequencer configurations (16 and 5 taps)
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_tap_sequencer;

    localparam int DW      = 16;
    localparam int AW0     = 4;
    localparam int AW1     = 3;
    localparam int N_CYCLE = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [2];
    logic          valid [2];
    logic [DW-1:0] data  [2];
    logic          ovf   [2];

    logic           rdy0, we0, tv0, sz0, ow0, lt0, stk0;
    logic [AW0-1:0] wa0, sa0, ca0;
    logic [DW-1:0]  wd0;
    logic           rdy1, we1, tv1, sz1, ow1, lt1, stk1;
    logic [AW1-1:0] wa1, sa1, ca1;
    logic [DW-1:0]  wd1;

    fir_filter_tap_sequencer #(.TAP_COUNT(16), .ADDR_WIDTH(AW0), .DATA_WIDTH(DW)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .sample_valid_in(valid[0]), .sample_data_in(data[0]), .sample_ready_out(rdy0),
        .write_en_out(we0), .write_addr_out(wa0), .write_data_out(wd0),
        .sample_addr_out(sa0), .coeff_addr_out(ca0), .tap_valid_out(tv0),
        .sample_zero_out(sz0), .overwrite_out(ow0), .last_tap_out(lt0),
        .overflow_in(ovf[0]), .overflow_sticky_out(stk0)
    );

    fir_filter_tap_sequencer #(.TAP_COUNT(5), .ADDR_WIDTH(AW1), .DATA_WIDTH(DW)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .sample_valid_in(valid[1]), .sample_data_in(data[1]), .sample_ready_out(rdy1),
        .write_en_out(we1), .write_addr_out(wa1), .write_data_out(wd1),
        .sample_addr_out(sa1), .coeff_addr_out(ca1), .tap_valid_out(tv1),
        .sample_zero_out(sz1), .overwrite_out(ow1), .last_tap_out(lt1),
        .overflow_in(ovf[1]), .overflow_sticky_out(stk1)
    );

    // Reference model: one output per accepted sample, TAP_COUNT taps long.
    int m_tc     [2] = '{16, 5};
    int m_wr     [2];
    int m_fill   [2];
    int m_busy   [2];
    int m_k      [2];
    int m_newest [2];
    int m_stk    [2];

    int ob_rdy [2], ob_we [2], ob_wa [2], ob_wd [2], ob_tv [2], ob_sa [2];
    int ob_ca  [2], ob_sz [2], ob_ow [2], ob_lt [2], ob_stk [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic capture_outputs();
        ob_rdy[0] = int'(rdy0); ob_we[0] = int'(we0); ob_wa[0] = int'(wa0);
        ob_wd[0]  = int'(wd0);  ob_tv[0] = int'(tv0); ob_sa[0] = int'(sa0);
        ob_ca[0]  = int'(ca0);  ob_sz[0] = int'(sz0); ob_ow[0] = int'(ow0);
        ob_lt[0]  = int'(lt0);  ob_stk[0] = int'(stk0);
        ob_rdy[1] = int'(rdy1); ob_we[1] = int'(we1); ob_wa[1] = int'(wa1);
        ob_wd[1]  = int'(wd1);  ob_tv[1] = int'(tv1); ob_sa[1] = int'(sa1);
        ob_ca[1]  = int'(ca1);  ob_sz[1] = int'(sz1); ob_ow[1] = int'(ow1);
        ob_lt[1]  = int'(lt1);  ob_stk[1] = int'(stk1);
    endtask

    task automatic drive_inputs(input int i, input int cyc);
        int fill_len;
        fill_len = 2 + 19 * (m_tc[i] + 1);
        if (cyc < 2) begin
            rst[i] = 1'b1; valid[i] = 1'b0; data[i] = '0; ovf[i] = 1'b0;
        end else if (cyc < fill_len) begin
            // Valid held high: accepts are paced purely by the sequencer.
            rst[i]   = 1'b0;
            valid[i] = 1'b1;
            data[i]  = (cyc == 2) ? 16'h0005 : DW'($urandom);
            ovf[i]   = (m_busy[i] != 0) && ($urandom_range(0, 19) == 0);
        end else begin
            rst[i]   = ($urandom_range(0, 199) == 0);
            valid[i] = !rst[i] && ($urandom_range(0, 2) == 0);
            data[i]  = DW'($urandom);
            ovf[i]   = (!valid[i] || m_busy[i] != 0) && ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic check_and_update(input int i);
        string p;
        int    tc;
        int    acc;
        p   = $sformatf("u%0d", i);
        tc  = m_tc[i];
        acc = (valid[i] && m_busy[i] == 0) ? 1 : 0;

        check_value({p, " ready"}, ob_rdy[i], (m_busy[i] == 0) ? 1 : 0);
        check_value({p, " tap_valid"}, ob_tv[i], m_busy[i]);
        check_value({p, " write_en"}, ob_we[i], acc);
        check_value({p, " sticky"}, ob_stk[i], m_stk[i]);
        if (acc != 0) begin
            check_value({p, " write_addr"}, ob_wa[i], m_wr[i]);
            check_value({p, " write_data"}, ob_wd[i], int'(data[i]));
        end
        if (m_busy[i] != 0) begin
            check_value({p, " coeff_addr"}, ob_ca[i], m_k[i]);
            check_value({p, " sample_addr"}, ob_sa[i], (m_newest[i] - m_k[i] + tc) % tc);
            check_value({p, " sample_zero"}, ob_sz[i], (m_k[i] >= m_fill[i]) ? 1 : 0);
            check_value({p, " overwrite"}, ob_ow[i], (m_k[i] == 0) ? 1 : 0);
            check_value({p, " last_tap"}, ob_lt[i], (m_k[i] == tc - 1) ? 1 : 0);
        end else begin
            check_value({p, " idle last_tap"}, ob_lt[i], 0);
            check_value({p, " idle overwrite"}, ob_ow[i], 0);
        end

        if (rst[i]) begin
            m_wr[i] = 0; m_fill[i] = 0; m_busy[i] = 0; m_k[i] = 0; m_stk[i] = 0;
        end else if (acc != 0) begin
            m_newest[i] = m_wr[i];
            m_wr[i]     = (m_wr[i] + 1) % tc;
            m_fill[i]   = (m_fill[i] < tc) ? m_fill[i] + 1 : tc;
            m_busy[i]   = 1;
            m_k[i]      = 0;
            m_stk[i]    = 0;
        end else begin
            if (m_busy[i] != 0) begin
                if (m_k[i] == tc - 1) m_busy[i] = 0;
                else                  m_k[i]++;
            end
            if (ovf[i]) m_stk[i] = 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; data[i] = '0; ovf[i] = 1'b0;
            m_wr[i] = 0; m_fill[i] = 0; m_busy[i] = 0; m_k[i] = 0;
            m_newest[i] = 0; m_stk[i] = 0;
        end
        for (int cyc = 0; cyc < N_CYCLE; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) drive_inputs(i, cyc);
            @(negedge clk);
            capture_outputs();
            for (int i = 0; i < 2; i++) check_and_update(i);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
